// File: rtl/de4_sysid_checker.sv
// rtl/de4_sysid_checker.sv - boot-time sysid read-and-compare controller
// Reads sysid word 0 (ID) and word 1 (timestamp) over Avalon-MM, retries on mismatch/timeout, latches a verdict.
module de4_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1433947896,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  attempts
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID_REQ,
    S_ID_WAIT,
    S_TS_REQ,
    S_TS_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  RETRY_LIMIT = 5'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic        auto_q, auto_d;
  logic [15:0] tmo_q, tmo_d;
  logic [4:0]  att_q, att_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;

  logic launch;
  logic in_flight;
  logic timeout;
  logic retry;

  assign launch    = start || auto_q;
  assign in_flight = state_q inside {S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT};
  // The timeout wins over a same-cycle accept/response so the counter never runs past the limit.
  assign timeout   = in_flight && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    auto_d  = 1'b0;
    tmo_d   = tmo_q;
    att_d   = att_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    id_d    = id_q;
    ts_d    = ts_q;
    retry   = 1'b0;

    if (in_flight) begin
      tmo_d = tmo_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (launch) begin
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          att_d   = 5'd1;
          tmo_d   = 16'd0;
          state_d = S_ID_REQ;
        end
      end
      S_ID_REQ: begin
        if (timeout)             retry   = 1'b1;
        else if (!m_waitrequest) state_d = S_ID_WAIT;
      end
      S_ID_WAIT: begin
        if (timeout) begin
          retry = 1'b1;
        end else if (m_readdatavalid) begin
          id_d    = m_readdata;
          tmo_d   = 16'd0;
          state_d = S_TS_REQ;
        end
      end
      S_TS_REQ: begin
        if (timeout)             retry   = 1'b1;
        else if (!m_waitrequest) state_d = S_TS_WAIT;
      end
      S_TS_WAIT: begin
        if (timeout) begin
          retry = 1'b1;
        end else if (m_readdatavalid) begin
          ts_d    = m_readdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP)) begin
          pass_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          retry = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Attempt counter is one bit wider than the port so MAX_RETRIES=15 still terminates.
    if (retry) begin
      if (att_q <= RETRY_LIMIT) begin
        att_d   = att_q + 5'd1;
        tmo_d   = 16'd0;
        state_d = S_ID_REQ;
      end else begin
        fail_d  = 1'b1;
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      auto_q  <= AUTO_START;
      tmo_q   <= 16'd0;
      att_q   <= 5'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      tmo_q   <= tmo_d;
      att_q   <= att_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign m_read    = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
  assign m_address = (state_q == S_TS_REQ);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign id_value  = id_q;
  assign ts_value  = ts_q;
  assign attempts  = att_q[4] ? 4'hF : att_q[3:0];

endmodule

// File: tb/tb_de4_sysid_checker.sv
// tb/tb_de4_sysid_checker.sv - self-checking bench for de4_sysid_checker
// Randomized sysid slave model; expected verdicts and latencies derived from the read/retry rules.
module tb_de4_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1433947896;
  localparam int          MAXR   = 3;
  localparam int          TMO_T  = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        m_address, m_read, m_waitrequest, m_readdatavalid;
  logic [31:0] m_readdata;
  logic        busy, done, pass, fail;
  logic [31:0] id_value, ts_value;
  logic [3:0]  attempts;

  logic        start_t = 1'b0;
  logic        wr_t    = 1'b1;
  logic        rdv_t   = 1'b0;
  logic [31:0] rdata_t = 32'd0;
  logic        m_address_t, m_read_t, busy_t, done_t, pass_t, fail_t;
  logic [31:0] id_value_t, ts_value_t;
  logic [3:0]  attempts_t;

  int checks   = 0;
  int failures = 0;

  int   max_wait    = 0;
  int   min_delay   = 1;
  int   max_delay   = 1;
  int   bad_ts_left = 0;
  int   lat_sum     = 0;
  bit   stray_en    = 1'b0;
  logic acc_addr[$];

  always #5 clock = ~clock;

  de4_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .MAX_RETRIES(MAXR),
    .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .id_value(id_value), .ts_value(ts_value), .attempts(attempts)
  );

  de4_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .MAX_RETRIES(0),
    .TIMEOUT_CYCLES(TMO_T), .AUTO_START(1'b0)
  ) dut_t (
    .clock(clock), .reset(reset), .start(start_t),
    .m_address(m_address_t), .m_read(m_read_t), .m_waitrequest(wr_t),
    .m_readdata(rdata_t), .m_readdatavalid(rdv_t),
    .busy(busy_t), .done(done_t), .pass(pass_t), .fail(fail_t),
    .id_value(id_value_t), .ts_value(ts_value_t), .attempts(attempts_t)
  );

  // Sysid slave: random stall, random response delay, optional stray strobes.
  initial begin : slave
    bit   pend, req_seen, sent;
    int   stall_left, stall_pick, delay_left;
    logic pend_addr;
    pend = 0; req_seen = 0; sent = 0;
    stall_left = 0; stall_pick = 0; delay_left = 0; pend_addr = 1'b0;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = 32'd0;
    forever begin
      @(negedge clock);
      m_readdatavalid = 1'b0;
      sent = 0;
      if (pend) begin
        if (delay_left <= 1) begin
          m_readdatavalid = 1'b1;
          sent = 1;
          pend = 0;
          if (!pend_addr) m_readdata = EXP_ID;
          else if (bad_ts_left > 0) begin
            m_readdata = EXP_TS + 32'd1;
            bad_ts_left--;
          end else m_readdata = EXP_TS;
        end else delay_left--;
      end
      if (m_read === 1'b1 && pend) begin
        m_waitrequest = 1'b1;
      end else if (m_read === 1'b1) begin
        if (!req_seen) begin
          req_seen   = 1;
          stall_pick = $urandom_range(0, max_wait);
          stall_left = stall_pick;
        end
        if (stall_left > 0) begin
          m_waitrequest = 1'b1;
          stall_left--;
        end else begin
          m_waitrequest = 1'b0;
          req_seen      = 0;
          pend          = 1;
          pend_addr     = m_address;
          delay_left    = $urandom_range(min_delay, max_delay);
          lat_sum       += 1 + stall_pick + delay_left;
          acc_addr.push_back(m_address);
        end
      end else begin
        m_waitrequest = 1'b0;
      end
      if (!sent && stray_en && ($urandom_range(0, 2) == 0) &&
          (m_read === 1'b1 || done === 1'b1 || (busy === 1'b1 && !pend))) begin
        m_readdatavalid = 1'b1;
        m_readdata      = $urandom;
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic run_check(input int limit, input int busy_pulse_at, output int n);
    start = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      start = (n == busy_pulse_at);
    end while (done !== 1'b1 && n < limit);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_t = 1'b1;
    repeat (3) step();
    checks++;
    if ({busy, done, pass, fail, m_read, m_address} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000", {busy, done, pass, fail, m_read, m_address});
    end
    checks++;
    if (id_value !== 32'd0 || ts_value !== 32'd0 || attempts !== 4'd0) begin
      failures++;
      $display("FAIL reset_values: got id=%0d ts=%0d att=%0d expected 0 0 0", id_value, ts_value, attempts);
    end
  endtask

  task automatic test_auto_start();
    int n;
    max_wait = 0; min_delay = 1; max_delay = 1;
    acc_addr.delete();
    lat_sum = 0;
    reset = 1'b0;
    start_t = 1'b0;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL auto_busy_rise: got %b expected 1", busy);
        end
      end
    end while (done !== 1'b1 && n < 40);
    checks++;
    if (n !== 6) begin
      failures++;
      $display("FAIL auto_latency: got %0d expected 6", n);
    end
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0 || attempts !== 4'd1) begin
      failures++;
      $display("FAIL auto_verdict: got pass=%b fail=%b att=%0d expected 1 0 1", pass, fail, attempts);
    end
    checks++;
    if (acc_addr.size() != 2 || acc_addr[0] !== 1'b0 || acc_addr[1] !== 1'b1) begin
      failures++;
      $display("FAIL auto_reads: got %0d accepted reads expected 2 (addr 0 then 1)", acc_addr.size());
    end
    checks++;
    if (id_value !== EXP_ID || ts_value !== EXP_TS) begin
      failures++;
      $display("FAIL auto_capture: got id=%0d ts=%0d expected %0d %0d", id_value, ts_value, EXP_ID, EXP_TS);
    end
    checks++;
    if (busy_t !== 1'b0) begin
      failures++;
      $display("FAIL start_with_reset: got busy=%b expected 0", busy_t);
    end
  endtask

  task automatic test_retry_once();
    int n;
    acc_addr.delete();
    lat_sum = 0;
    bad_ts_left = 1;
    run_check(100, -1, n);
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0 || attempts !== 4'd2) begin
      failures++;
      $display("FAIL retry_once: got pass=%b fail=%b att=%0d expected 1 0 2", pass, fail, attempts);
    end
    checks++;
    if (n !== lat_sum + 2 + 1 || acc_addr.size() != 4) begin
      failures++;
      $display("FAIL retry_once_timing: got n=%0d reads=%0d expected n=%0d reads=4", n, acc_addr.size(), lat_sum + 3);
    end
  endtask

  task automatic test_retry_exhaust();
    int n;
    acc_addr.delete();
    bad_ts_left = 100;
    run_check(200, -1, n);
    bad_ts_left = 0;
    checks++;
    if (done !== 1'b1 || fail !== 1'b1 || pass !== 1'b0 || attempts !== 4'(MAXR + 1)) begin
      failures++;
      $display("FAIL retry_exhaust: got done=%b fail=%b pass=%b att=%0d expected 1 1 0 %0d",
               done, fail, pass, attempts, MAXR + 1);
    end
    checks++;
    if (ts_value !== EXP_TS + 32'd1 || acc_addr.size() != 2 * (MAXR + 1)) begin
      failures++;
      $display("FAIL retry_exhaust_data: got ts=%0d reads=%0d expected %0d %0d",
               ts_value, acc_addr.size(), EXP_TS + 32'd1, 2 * (MAXR + 1));
    end
  endtask

  task automatic test_timeout();
    int  n, high;
    bit  addr_bad;
    n = 0; high = 0; addr_bad = 0;
    start_t = 1'b1;
    do begin
      step();
      n++;
      start_t = 1'b0;
      if (m_read_t === 1'b1) high++;
      if (m_address_t !== 1'b0) addr_bad = 1;
    end while (done_t !== 1'b1 && n < 60);
    checks++;
    if (high !== TMO_T) begin
      failures++;
      $display("FAIL timeout_read_cycles: got %0d expected %0d", high, TMO_T);
    end
    checks++;
    if (done_t !== 1'b1 || fail_t !== 1'b1 || pass_t !== 1'b0 || busy_t !== 1'b0 || attempts_t !== 4'd1) begin
      failures++;
      $display("FAIL timeout_verdict: got done=%b fail=%b pass=%b busy=%b att=%0d expected 1 1 0 0 1",
               done_t, fail_t, pass_t, busy_t, attempts_t);
    end
    checks++;
    if (addr_bad) begin
      failures++;
      $display("FAIL timeout_address: got nonzero address expected 0");
    end
  endtask

  task automatic test_random_stalls();
    int          n, a, bad, exp_n;
    bit          pass_exp, seq_ok;
    logic [31:0] ts_exp;
    max_wait = 5; min_delay = 1; max_delay = 5; stray_en = 1'b1;
    for (int it = 0; it < 12; it++) begin
      bad = $urandom_range(0, 5);
      bad_ts_left = bad;
      acc_addr.delete();
      lat_sum = 0;
      run_check(800, 3, n);
      pass_exp = (bad <= MAXR);
      a        = pass_exp ? bad + 1 : MAXR + 1;
      ts_exp   = pass_exp ? EXP_TS : EXP_TS + 32'd1;
      exp_n    = lat_sum + a + 1;
      seq_ok   = (acc_addr.size() == 2 * a);
      for (int i = 0; i < acc_addr.size(); i++)
        if (acc_addr[i] !== 1'(i % 2)) seq_ok = 0;
      checks++;
      if (n !== exp_n) begin
        failures++;
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, n, exp_n);
      end
      checks++;
      if (pass !== pass_exp || fail !== !pass_exp || attempts !== 4'(a)) begin
        failures++;
        $display("FAIL rand_verdict[%0d]: got pass=%b fail=%b att=%0d expected %b %b %0d",
                 it, pass, fail, attempts, pass_exp, !pass_exp, a);
      end
      checks++;
      if (id_value !== EXP_ID || ts_value !== ts_exp || !seq_ok) begin
        failures++;
        $display("FAIL rand_capture[%0d]: got id=%0d ts=%0d seq_ok=%b expected %0d %0d 1",
                 it, id_value, ts_value, seq_ok, EXP_ID, ts_exp);
      end
      repeat (3) step();
      checks++;
      if (done !== 1'b1 || id_value !== EXP_ID || ts_value !== ts_exp) begin
        failures++;
        $display("FAIL rand_done_hold[%0d]: got done=%b id=%0d ts=%0d expected 1 %0d %0d",
                 it, done, id_value, ts_value, EXP_ID, ts_exp);
      end
    end
    stray_en = 1'b0;
    bad_ts_left = 0;
  endtask

  task automatic test_reset_mid_check();
    int n, base;
    max_wait = 0; min_delay = 5; max_delay = 5;
    base = acc_addr.size();
    start = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      start = 1'b0;
    end while (acc_addr.size() < base + 2 && n < 50);
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({busy, done, pass, fail, m_read, m_address} !== 6'b0 ||
        id_value !== 32'd0 || ts_value !== 32'd0 || attempts !== 4'd0) begin
      failures++;
      $display("FAIL midcheck_reset: got flags=%b id=%0d ts=%0d att=%0d expected all 0",
               {busy, done, pass, fail, m_read, m_address}, id_value, ts_value, attempts);
    end
    reset = 1'b0;
    min_delay = 1; max_delay = 1;
    n = 0;
    do begin
      step();
      n++;
    end while (done !== 1'b1 && n < 100);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || attempts !== 4'd1) begin
      failures++;
      $display("FAIL midcheck_recover: got done=%b pass=%b att=%0d expected 1 1 1", done, pass, attempts);
    end
    checks++;
    if (id_value !== EXP_ID || ts_value !== EXP_TS) begin
      failures++;
      $display("FAIL midcheck_capture: got id=%0d ts=%0d expected %0d %0d", id_value, ts_value, EXP_ID, EXP_TS);
    end
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_retry_once();
    test_retry_exhaust();
    test_timeout();
    test_random_stalls();
    test_reset_mid_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
